// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC phase-error post-processing slice.
package tdc_pkg;

  localparam int unsigned TDC_BITS = 6;
  localparam int unsigned PHE_BITS = 7;

  typedef logic [TDC_BITS-1:0]        tdc_code_t;
  typedef logic signed [PHE_BITS-1:0] phe_t;

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} cal_state_t;

  localparam tdc_code_t CODE_MAX = '1;

endpackage

// File: rtl/tdc_phe_proc_if.sv
// Data/control bundle between the TDC decoder side and the phase-error processor.
interface tdc_phe_proc_if;
  import tdc_pkg::*;

  tdc_code_t CODE;
  logic      EN;
  logic      CAL_START;
  logic      OFFSET_SEL;
  tdc_code_t OFFSET_OVR;
  phe_t      PHE;
  logic      PHE_VLD;
  logic      CAL_BUSY;
  logic      CAL_DONE;
  tdc_code_t CAL_MEAN;
  tdc_code_t CAL_RANGE;

  modport master (
    output CODE, EN, CAL_START, OFFSET_SEL, OFFSET_OVR,
    input  PHE, PHE_VLD, CAL_BUSY, CAL_DONE, CAL_MEAN, CAL_RANGE
  );

  modport slave (
    input  CODE, EN, CAL_START, OFFSET_SEL, OFFSET_OVR,
    output PHE, PHE_VLD, CAL_BUSY, CAL_DONE, CAL_MEAN, CAL_RANGE
  );

endinterface

// File: rtl/tdc_stat_acc.sv
// Calibration statistics: sample sum, min/max spread, sample count and rounded mean.
module tdc_stat_acc
  import tdc_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic      CLKY,
  input  logic      NRST,
  input  logic      clr,
  input  logic      en,
  input  tdc_code_t code,
  output logic      last,
  output tdc_code_t mean,
  output tdc_code_t spread
);

  localparam int unsigned AccW = TDC_BITS + AVG_LOG2;
  localparam logic [AccW:0] Half = (AccW + 1)'(1) << (AVG_LOG2 - 1);

  logic [AccW-1:0]     acc_q;
  logic [AVG_LOG2-1:0] cnt_q;
  tdc_code_t           min_q;
  tdc_code_t           max_q;
  logic [AccW:0]       rnd;
  logic [AccW:0]       shifted;

  // Accumulate one sample per enabled cycle; clr re-arms for a new window.
  always_ff @(posedge CLKY or negedge NRST) begin
    if (!NRST) begin
      acc_q <= '0;
      cnt_q <= '0;
      min_q <= CODE_MAX;
      max_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      cnt_q <= '0;
      min_q <= CODE_MAX;
      max_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + AccW'(code);
      cnt_q <= cnt_q + 1'b1;
      if (code < min_q) min_q <= code;
      if (code > max_q) max_q <= code;
    end
  end

  // Round-half-up mean with saturation; last flags the final sample of the window.
  always_comb begin
    rnd     = {1'b0, acc_q} + Half;
    shifted = rnd >> AVG_LOG2;
    mean    = (shifted > (AccW + 1)'(CODE_MAX)) ? CODE_MAX : shifted[TDC_BITS-1:0];
    spread  = max_q - min_q;
    last    = en && (&cnt_q);
  end

endmodule

// File: rtl/tdc_phe_proc.sv
// TDC post-processing: registers the code, subtracts the offset and runs offset calibration.
module tdc_phe_proc
  import tdc_pkg::*;
#(
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned OFFSET_RST = 0
) (
  input  logic           CLKY,
  input  logic           NRST,
  tdc_phe_proc_if.slave  bus
);

  localparam tdc_code_t  OffsetRst  = tdc_code_t'(OFFSET_RST);
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);

  tdc_code_t  code_q;
  phe_t       phe_q;
  logic       phe_vld_q;
  tdc_code_t  offset_cal_q;
  tdc_code_t  cal_range_q;
  tdc_code_t  offset_eff;
  cal_state_t state_q, state_d;
  logic [7:0] settle_cnt_q;
  logic       st_clr, st_en, st_last;
  logic       cal_busy, cal_done;
  tdc_code_t  st_mean, st_spread;

  tdc_stat_acc #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_stat_acc (
    .CLKY   (CLKY),
    .NRST   (NRST),
    .clr    (st_clr),
    .en     (st_en),
    .code   (code_q),
    .last   (st_last),
    .mean   (st_mean),
    .spread (st_spread)
  );

  assign offset_eff = bus.OFFSET_SEL ? bus.OFFSET_OVR : offset_cal_q;

  // Code capture and phase-error register; PHE holds while EN is low.
  always_ff @(posedge CLKY or negedge NRST) begin
    if (!NRST) begin
      code_q    <= '0;
      phe_q     <= '0;
      phe_vld_q <= 1'b0;
    end else begin
      code_q    <= bus.CODE;
      phe_vld_q <= bus.EN;
      if (bus.EN) phe_q <= phe_t'({1'b0, code_q} - {1'b0, offset_eff});
    end
  end

  // Calibration FSM state register and settle counter.
  always_ff @(posedge CLKY or negedge NRST) begin
    if (!NRST) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= (state_q == SETTLE) ? settle_cnt_q + 1'b1 : '0;
    end
  end

  // Calibration FSM next-state logic; CAL_START is honoured only in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.CAL_START) state_d = (SETTLE_CYC == 0) ? ACCUM : SETTLE;
      SETTLE:  if (settle_cnt_q == SettleLast) state_d = ACCUM;
      ACCUM:   if (st_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Calibration FSM outputs.
  always_comb begin
    st_clr   = (state_q == IDLE) && bus.CAL_START;
    st_en    = (state_q == ACCUM);
    cal_busy = (state_q == SETTLE) || (state_q == ACCUM);
    cal_done = (state_q == DONE);
  end

  // Latch calibration results when leaving DONE; they hold until the next run completes.
  always_ff @(posedge CLKY or negedge NRST) begin
    if (!NRST) begin
      offset_cal_q <= OffsetRst;
      cal_range_q  <= '0;
    end else if (state_q == DONE) begin
      offset_cal_q <= st_mean;
      cal_range_q  <= st_spread;
    end
  end

  assign bus.PHE       = phe_q;
  assign bus.PHE_VLD   = phe_vld_q;
  assign bus.CAL_BUSY  = cal_busy;
  assign bus.CAL_DONE  = cal_done;
  assign bus.CAL_MEAN  = offset_cal_q;
  assign bus.CAL_RANGE = cal_range_q;

endmodule

// File: doc/tdc_phe_proc.md
Name: tdc_phe_proc

Overview:
Post-processing stage directly downstream of the 64-tap TDC and its thermometer-to-binary decoder, clocked by the same CLKY sampling clock. Registers the 6-bit TDC code, removes a static offset, and emits a signed phase-error word to the digital loop filter. A built-in calibration FSM averages 2^AVG_LOG2 codes to measure the offset and tracks the min/max code spread.

Parameters:
AVG_LOG2, 4, log2 of calibration sample count; legal range 1..10
SETTLE_CYC, 2, CLKY cycles discarded after CAL_START before accumulation; legal range 0..255
OFFSET_RST, 0, reset value of the calibrated offset register (0..63)

Ports:
NRST  input  1  asynchronous active-low reset
CLKY  input  1  clock (TDC sampling clock)
CODE  input  6  decoded TDC code; changes after each CLKY rising edge, stable before the next
EN  input  1  phase-error output enable
CAL_START  input  1  single-cycle calibration request
OFFSET_SEL  input  1  1 = use OFFSET_OVR, 0 = use calibrated offset
OFFSET_OVR  input  6  manual offset override
PHE  output  7  signed phase error = code_r - offset_eff, two's complement
PHE_VLD  output  1  PHE updated this cycle
CAL_BUSY  output  1  calibration in progress
CAL_DONE  output  1  one-cycle pulse when calibration completes
CAL_MEAN  output  6  last calibrated mean (equals offset_cal)
CAL_RANGE  output  6  last max - min code over the calibration window

Behaviour:
- Reset state (NRST low, async): code_r=0, PHE=0, PHE_VLD=0, CAL_BUSY=0, CAL_DONE=0, offset_cal=OFFSET_RST, CAL_MEAN=OFFSET_RST, CAL_RANGE=0, FSM=IDLE, accumulator and counters cleared.
- Pipeline: CODE is captured into code_r at CLKY edge n. PHE is registered at edge n+1, giving 2-edge latency from the TDC sampling edge.
- Effective offset: offset_eff = OFFSET_SEL ? OFFSET_OVR : offset_cal. It is sampled combinationally at the PHE register, so an offset change takes effect on the next PHE.
- PHE arithmetic: zero-extend both operands to 7 bits and subtract. The result range is -63..+63, so no saturation is needed.
- EN=1: PHE updates every cycle and PHE_VLD=1. EN=0: PHE holds and PHE_VLD=0. Calibration runs independent of EN.
- FSM states:
  - IDLE: CAL_START=1 moves to SETTLE, or directly to ACCUM if SETTLE_CYC=0. The transition clears the accumulator and sample counter and sets min=63, max=0. CAL_BUSY=1 from the next cycle.
  - SETTLE: count SETTLE_CYC cycles, then go to ACCUM.
  - ACCUM: each cycle, acc += code_r (acc width 6+AVG_LOG2), min=min(min,code_r), max=max(max,code_r). After exactly 2^AVG_LOG2 samples, go to DONE.
  - DONE (one cycle):
    - mean = (acc + 2^(AVG_LOG2-1)) >> AVG_LOG2, round-half-up, saturated to 63.
    - offset_cal, CAL_MEAN <= mean; CAL_RANGE <= max-min.
    - CAL_DONE=1 for this cycle; CAL_BUSY drops; return to IDLE.
- CAL_START while CAL_BUSY=1 is ignored, with no restart.
- CAL_START during the DONE cycle is ignored; a new calibration needs CAL_START while in IDLE.
- PHE during calibration keeps using the old offset_eff; the new offset applies from the cycle after DONE.
- NRST asserted mid-calibration aborts the run. All state returns to reset values and the partial result is discarded.
- CAL_MEAN and CAL_RANGE hold between calibrations.

Decomposition:
- Package tdc_pkg:
  - TDC_BITS=6, PHE_BITS=7
  - typedef tdc_code_t (logic [5:0]), typedef phe_t (logic signed [6:0])
  - enum cal_state_t {IDLE, SETTLE, ACCUM, DONE}
- Sub-module tdc_stat_acc: accumulator, min/max tracking, sample counter, and rounded-mean computation. Controlled by clear/enable from the FSM in the top.

Test Plan:
- Reset/idle: NRST low, then high, CODE=37, EN=1, OFFSET_SEL=0 (OFFSET_RST=0) -> PHE=+37 two edges after CODE presented; PHE_VLD=1; CAL_MEAN=0, CAL_RANGE=0.
- Constant calibration: CODE held 20, CAL_START pulse -> CAL_DONE pulses after 1+2+16 cycles; CAL_MEAN=20, CAL_RANGE=0; next PHE with CODE=5 is -15 (7'b1110001).
- Rounding/spread: CODE alternating 10/13 over the window (sum 184) -> CAL_MEAN=12 (11.5 rounds up), CAL_RANGE=3.
- Extremes/override: OFFSET_SEL=1, OFFSET_OVR=0, CODE=63 -> PHE=+63. Then OFFSET_OVR=63, CODE=0 -> PHE=-63. Constant-63 calibration -> CAL_MEAN=63, no overflow.
- EN gating: EN=0 for 5 cycles while CODE varies -> PHE frozen, PHE_VLD=0. EN back to 1 -> tracks within 2 edges.
- Abort/ignore: second CAL_START mid-ACCUM does not extend the run (CAL_DONE still at cycle 19). NRST pulse at ACCUM sample 8 -> CAL_BUSY=0, CAL_MEAN=OFFSET_RST, no CAL_DONE.
